// File: rtl/commit_trace_fifo.sv
//------------------------------------------------------------------------------
// Module  : commit_trace_fifo
// Brief   : W-stage commit record capture FIFO with retire counting, overflow,
//           backpressure and ebreak-driven drain/halt toward a debug host.
//           Optional PC-continuity checker: define COMMIT_TRACE_PC_CHECK_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module commit_trace_fifo #(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_commit,
    input  logic [63:0] in_pre_pc,
    input  logic [31:0] in_instr,
    input  logic [63:0] in_pc,
    output logic        in_stall,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pre_pc,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic [63:0] retire_cnt,
    output logic        overflow,
    output logic        halted,
    output logic        pc_err,
    output logic [63:0] pc_err_pc
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              CW         = AW + 1;
    localparam int              RW         = 160;
    localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0]   AFULL_C    = CW'(AFULL_LVL);
    localparam logic [31:0]     EBREAK     = 32'h0010_0073;

    localparam logic [1:0]      ST_RUN     = 2'd0;
    localparam logic [1:0]      ST_DRAIN   = 2'd1;
    localparam logic [1:0]      ST_HALTED  = 2'd2;

    logic [RW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic [1:0]     state;
    logic [1:0]     state_next;

    logic           in_run;
    logic           push_req;
    logic           pop;
    logic           push;
    logic           drop;
    logic [RW-1:0]  head;

    assign in_run   = (state == ST_RUN);
    assign push_req = in_commit && in_run;
    assign pop      = (count != '0) && out_ready;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign push     = push_req && ((count < DEPTH_C) || pop);
    assign drop     = push_req && !push;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_pre_pc, in_instr, in_pc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            retire_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count      <= count_next;
            retire_cnt <= retire_cnt + 64'(push_req);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (push_req && (in_instr == EBREAK)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_next == '0) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    always_comb begin
        halted   = (state == ST_HALTED);
        in_stall = (state != ST_HALTED) && ((DEPTH_C - count) <= AFULL_C);
    end

    // Empty FIFO presents zeros so outputs are defined straight out of reset.
    assign out_valid = (count != '0);
    assign head      = out_valid ? mem[rd_ptr] : '0;
    assign out_pre_pc = head[159:96];
    assign out_instr  = head[95:64];
    assign out_pc     = head[63:0];

`ifdef COMMIT_TRACE_PC_CHECK_EN
    logic [63:0] last_pc;
    logic        seen_first;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_pc    <= '0;
            seen_first <= 1'b0;
            pc_err     <= 1'b0;
            pc_err_pc  <= '0;
        end else if (push_req) begin
            last_pc    <= in_pc;
            seen_first <= 1'b1;
            if (seen_first && (in_pre_pc != last_pc) && !pc_err) begin
                pc_err    <= 1'b1;
                pc_err_pc <= in_pre_pc;
            end
        end
    end
`else
    assign pc_err    = 1'b0;
    assign pc_err_pc = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_fifo.sv
//------------------------------------------------------------------------------
// Module  : tb_commit_trace_fifo
// Brief   : Self-checking bench for commit_trace_fifo against a queue model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_commit_trace_fifo;

    localparam int          DEPTH  = 8;
    localparam int          AFULL  = 2;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_commit = 1'b0;
    logic [63:0] in_pre_pc = '0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        out_ready = 1'b0;
    logic        in_stall;
    logic        out_valid;
    logic [63:0] out_pre_pc;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [63:0] retire_cnt;
    logic        overflow;
    logic        halted;
    logic        pc_err;
    logic [63:0] pc_err_pc;

    commit_trace_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_commit  (in_commit),
        .in_pre_pc  (in_pre_pc),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_stall   (in_stall),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pre_pc (out_pre_pc),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .retire_cnt (retire_cnt),
        .overflow   (overflow),
        .halted     (halted),
        .pc_err     (pc_err),
        .pc_err_pc  (pc_err_pc)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a queue of records plus a few flags.
    logic [159:0] q[$];
    logic [63:0]  m_ret;
    bit           m_ovf, m_drain, m_halt;
    bit           m_seen, m_pcerr;
    logic [63:0]  m_last, m_pcerrpc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ret = '0; m_ovf = 0; m_drain = 0; m_halt = 0;
        m_seen = 0; m_pcerr = 0; m_last = '0; m_pcerrpc = '0;
    endtask

    task automatic check_all();
        logic [159:0] h;
        bit           stall;
        h     = (q.size() != 0) ? q[0] : '0;
        stall = !m_halt && ((DEPTH - q.size()) <= AFULL);
        chk("out_valid",  out_valid,  q.size() != 0);
        chk("out_pre_pc", out_pre_pc, h[159:96]);
        chk("out_instr",  out_instr,  h[95:64]);
        chk("out_pc",     out_pc,     h[63:0]);
        chk("retire_cnt", retire_cnt, m_ret);
        chk("overflow",   overflow,   m_ovf);
        chk("halted",     halted,     m_halt);
        chk("in_stall",   in_stall,   stall);
`ifdef COMMIT_TRACE_PC_CHECK_EN
        chk("pc_err",     pc_err,     m_pcerr);
        chk("pc_err_pc",  pc_err_pc,  m_pcerrpc);
`else
        chk("pc_err",     pc_err,     64'd0);
        chk("pc_err_pc",  pc_err_pc,  64'd0);
`endif
    endtask

    task automatic step(input bit c, input logic [63:0] pp, input logic [31:0] ins,
                        input logic [63:0] npc, input bit rdy);
        bit was_drain, run, pop;
        in_commit = c; in_pre_pc = pp; in_instr = ins; in_pc = npc; out_ready = rdy;
        was_drain = m_drain;
        run       = !m_drain && !m_halt;
        pop       = (q.size() != 0) && rdy;
        if (pop) void'(q.pop_front());
        if (run && c) begin
            m_ret++;
            if (q.size() < DEPTH) q.push_back({pp, ins, npc});
            else m_ovf = 1;
            if (ins == EBREAK) m_drain = 1;
            if (m_seen && pp != m_last && !m_pcerr) begin
                m_pcerr = 1; m_pcerrpc = pp;
            end
            m_last = npc; m_seen = 1;
        end
        if (was_drain && q.size() == 0) begin
            m_drain = 0; m_halt = 1;
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_commit = $urandom_range(0, 1);
        in_instr  = NOP;
        @(posedge clk); #1;
        model_clear();
        check_all();
        rst = 1'b0;
        in_commit = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, rdy);
    endtask

    initial begin
        logic [63:0] pc;
        model_clear();
        do_reset();

        // In-order streaming with a ready host
        for (int i = 0; i < 3; i++)
            step(1, 64'h8000_0000 + 64'(4 * i), NOP, 64'h8000_0004 + 64'(4 * i), 1);
        idle(2, 1);
        chk("t1_retire", retire_cnt, 64'd3);
        chk("t1_ovf", overflow, 64'd0);

        // Fill past capacity with host stalled
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1, 64'h9000_0000 + 64'(4 * i), NOP, 64'h9000_0004 + 64'(4 * i), 0);
        chk("t2_ovf", overflow, 64'd1);
        chk("t2_retire", retire_cnt, 64'd10);
        chk("t2_head", out_pre_pc, 64'h9000_0000);
        chk("t2_stall", in_stall, 64'd1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            step(1, 64'hA000_0000 + 64'(4 * i), NOP, 64'hA000_0004 + 64'(4 * i), 0);
        step(1, 64'hA000_0020, NOP, 64'hA000_0024, 1);
        chk("t3_ovf", overflow, 64'd0);
        chk("t3_head", out_pre_pc, 64'hA000_0004);
        idle(DEPTH, 1);

        // ebreak drain then halt
        do_reset();
        step(1, 64'h100, NOP, 64'h104, 0);
        step(1, 64'h104, NOP, 64'h108, 0);
        step(1, 64'h108, EBREAK, 64'h10C, 1);
        idle(3, 1);
        chk("t4_halted", halted, 64'd1);
        step(1, 64'h10C, NOP, 64'h110, 1);
        chk("t4_retire", retire_cnt, 64'd3);
        chk("t4_empty", out_valid, 64'd0);

        // Reset while draining
        do_reset();
        step(1, 64'h200, NOP, 64'h204, 0);
        step(1, 64'h204, NOP, 64'h208, 0);
        step(1, 64'h208, EBREAK, 64'h20C, 0);
        step(0, '0, '0, '0, 1);
        do_reset();
        chk("t5_valid", out_valid, 64'd0);
        chk("t5_halted", halted, 64'd0);
        step(1, 64'h300, NOP, 64'h304, 0);
        chk("t5_accept", out_pre_pc, 64'h300);

`ifdef COMMIT_TRACE_PC_CHECK_EN
        do_reset();
        step(1, 64'h8000_0000, NOP, 64'h8000_0004, 1);
        step(1, 64'h8000_0010, NOP, 64'h8000_0014, 1);
        chk("t6_pcerr", pc_err, 64'd1);
        chk("t6_pcerrpc", pc_err_pc, 64'h8000_0010);
        step(1, 64'h8000_0040, NOP, 64'h8000_0044, 1);
        chk("t6_sticky", pc_err_pc, 64'h8000_0010);
`endif

        // Randomized traffic, mostly contiguous PCs with occasional jumps
        do_reset();
        pc = 64'h8000_0000;
        for (int i = 0; i < 600; i++) begin
            if (m_halt || ($urandom_range(0, 199) == 0)) begin
                do_reset();
            end else begin
                logic [63:0] pre;
                logic [31:0] ins;
                bit          c;
                c   = ($urandom_range(0, 3) != 0);
                ins = ($urandom_range(0, 59) == 0) ? EBREAK : $urandom;
                pre = ($urandom_range(0, 29) == 0) ? {32'h0, $urandom} : pc;
                step(c, pre, ins, pre + 64'd4, ($urandom_range(0, 2) == 0));
                if (c) pc = pre + 64'd4;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
